// File: rtl/mult_rs.sv
// mult_rs: reservation station in front of one multi-cycle FU; holds ops until both sources are valid, snooping the CDB.
// Latency: a ready op issues at the first edge after its dispatch edge; a CDB-woken op issues one edge after its wakeup edge.
// Backpressure: disp_ready drops while every entry is valid; issue waits on fu_busy and leaves one idle cycle after each pulse.
module mult_rs #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4,
    parameter int DATAW = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [7:0]                 disp_operand,
    input  logic [1:0]                 disp_src_rdy,
    input  logic [2*TAGW-1:0]          disp_src_tag,
    input  logic [2*DATAW-1:0]         disp_src_val,
    input  logic [7:0]                 disp_wbs,
    input  logic [7:0]                 disp_flags,
    input  logic [TAGW-1:0]            disp_robid,
    input  logic                       cdb_valid,
    input  logic [TAGW-1:0]            cdb_id,
    input  logic [DATAW-1:0]           cdb_val,
    input  logic                       fu_busy,
    output logic                       issue_transmit,
    output logic [7:0]                 issue_operand,
    output logic [2*DATAW-1:0]         issue_depvals,
    output logic [7:0]                 issue_wbs,
    output logic [7:0]                 issue_flags,
    output logic [TAGW-1:0]            issue_robid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCCW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                       valid;
        logic [7:0]                 operand;
        logic [1:0]                 src_rdy;
        logic [1:0][TAGW-1:0]       src_tag;
        logic [1:0][DATAW-1:0]      src_val;
        logic [7:0]                 wbs;
        logic [7:0]                 flags;
        logic [TAGW-1:0]            robid;
        logic [AW-1:0]              age;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];

    logic                   issue_transmit_q;
    logic [7:0]             issue_operand_q;
    logic [2*DATAW-1:0]     issue_depvals_q;
    logic [7:0]             issue_wbs_q;
    logic [7:0]             issue_flags_q;
    logic [TAGW-1:0]        issue_robid_q;

    logic                   sel_vld;
    logic [AW-1:0]          sel_idx;
    logic [AW-1:0]          sel_age;
    logic                   free_vld;
    logic [AW-1:0]          free_idx;
    logic [OCCW-1:0]        occ_cnt;
    logic                   can_issue;
    logic                   disp_fire;

    // Pick the oldest eligible entry, the lowest free slot, and count valid entries.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        sel_age  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        occ_cnt  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && (&ent_q[i].src_rdy)) begin
                // Strict compare keeps the lower index on a tie.
                if (!sel_vld || (ent_q[i].age > sel_age)) begin
                    sel_vld = 1'b1;
                    sel_idx = AW'(i);
                    sel_age = ent_q[i].age;
                end
            end
            occ_cnt = occ_cnt + OCCW'(ent_q[i].valid);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_vld = 1'b1;
                free_idx = AW'(i);
            end
        end
    end

    // Ready depends on current state only, so a full station stays closed even in an issue cycle.
    assign disp_ready = free_vld;
    assign disp_fire  = disp_valid & free_vld;
    // The registered pulse blocks back-to-back issue, covering the cycle before the FU raises busy.
    assign can_issue  = sel_vld & ~fu_busy & ~issue_transmit_q;

    // Next entry state: CDB wakeup, age update, issue invalidate, dispatch write with CDB bypass.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            for (int s = 0; s < 2; s++) begin
                if (ent_q[i].valid && !ent_q[i].src_rdy[s] && cdb_valid &&
                    (ent_q[i].src_tag[s] == cdb_id)) begin
                    ent_d[i].src_val[s] = cdb_val;
                    ent_d[i].src_rdy[s] = 1'b1;
                end
            end
            if (ent_q[i].valid) begin
                // Ages stay a dense 0..n-1 ranking: the newcomer pushes everyone up,
                // and entries older than the issued one close the gap it leaves.
                if (disp_fire) begin
                    ent_d[i].age = ent_d[i].age + AW'(1);
                end
                if (can_issue && (ent_q[i].age > sel_age)) begin
                    ent_d[i].age = ent_d[i].age - AW'(1);
                end
            end
            if (can_issue && (sel_idx == AW'(i))) begin
                ent_d[i].valid = 1'b0;
            end
            if (disp_fire && (free_idx == AW'(i))) begin
                ent_d[i].valid   = 1'b1;
                ent_d[i].operand = disp_operand;
                ent_d[i].wbs     = disp_wbs;
                ent_d[i].flags   = disp_flags;
                ent_d[i].robid   = disp_robid;
                ent_d[i].age     = '0;
                for (int s = 0; s < 2; s++) begin
                    ent_d[i].src_tag[s] = disp_src_tag[s*TAGW +: TAGW];
                    if (disp_src_rdy[s]) begin
                        ent_d[i].src_rdy[s] = 1'b1;
                        ent_d[i].src_val[s] = disp_src_val[s*DATAW +: DATAW];
                    end else if (cdb_valid && (cdb_id == disp_src_tag[s*TAGW +: TAGW])) begin
                        ent_d[i].src_rdy[s] = 1'b1;
                        ent_d[i].src_val[s] = cdb_val;
                    end else begin
                        ent_d[i].src_rdy[s] = 1'b0;
                        ent_d[i].src_val[s] = disp_src_val[s*DATAW +: DATAW];
                    end
                end
            end
        end
    end

    // State and issue registers; reset and flush both clear everything, dropping any pending pulse.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            issue_transmit_q <= 1'b0;
            issue_operand_q  <= '0;
            issue_depvals_q  <= '0;
            issue_wbs_q      <= '0;
            issue_flags_q    <= '0;
            issue_robid_q    <= '0;
        end else begin
            ent_q            <= ent_d;
            issue_transmit_q <= can_issue;
            if (can_issue) begin
                issue_operand_q <= ent_q[sel_idx].operand;
                issue_depvals_q <= ent_q[sel_idx].src_val;
                issue_wbs_q     <= ent_q[sel_idx].wbs;
                issue_flags_q   <= ent_q[sel_idx].flags;
                issue_robid_q   <= ent_q[sel_idx].robid;
            end
        end
    end

    assign issue_transmit = issue_transmit_q;
    assign issue_operand  = issue_operand_q;
    assign issue_depvals  = issue_depvals_q;
    assign issue_wbs      = issue_wbs_q;
    assign issue_flags    = issue_flags_q;
    assign issue_robid    = issue_robid_q;
    assign occupancy      = occ_cnt;

endmodule

// File: tb/tb_mult_rs.sv
// tb_mult_rs: scoreboard bench for mult_rs; expected issues are queued at dispatch and compared as pulses appear.
// Latency: ready ops are expected at the first edge after their dispatch edge.
// Backpressure: fu_busy is driven by the bench to model a 9-cycle FU.
module tb_mult_rs;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [7:0]  disp_operand;
    logic [1:0]  disp_src_rdy;
    logic [7:0]  disp_src_tag;
    logic [15:0] disp_src_val;
    logic [7:0]  disp_wbs;
    logic [7:0]  disp_flags;
    logic [3:0]  disp_robid;
    logic        cdb_valid;
    logic [3:0]  cdb_id;
    logic [7:0]  cdb_val;
    logic        fu_busy;
    logic        issue_transmit;
    logic [7:0]  issue_operand;
    logic [15:0] issue_depvals;
    logic [7:0]  issue_wbs;
    logic [7:0]  issue_flags;
    logic [3:0]  issue_robid;
    logic [2:0]  occupancy;

    mult_rs #(.DEPTH(4), .TAGW(4), .DATAW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_operand   (disp_operand),
        .disp_src_rdy   (disp_src_rdy),
        .disp_src_tag   (disp_src_tag),
        .disp_src_val   (disp_src_val),
        .disp_wbs       (disp_wbs),
        .disp_flags     (disp_flags),
        .disp_robid     (disp_robid),
        .cdb_valid      (cdb_valid),
        .cdb_id         (cdb_id),
        .cdb_val        (cdb_val),
        .fu_busy        (fu_busy),
        .issue_transmit (issue_transmit),
        .issue_operand  (issue_operand),
        .issue_depvals  (issue_depvals),
        .issue_wbs      (issue_wbs),
        .issue_flags    (issue_flags),
        .issue_robid    (issue_robid),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  robid;
        logic [15:0] dep;
        logic [7:0]  op;
        logic [7:0]  wbs;
        logic [7:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_iss = -100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue monitor: every pulse must match the oldest queued expectation and respect the 2-cycle spacing.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (issue_transmit === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_issue", {28'd0, issue_robid}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("issue_robid",   {28'd0, issue_robid},   {28'd0, e.robid});
                check("issue_depvals", {16'd0, issue_depvals}, {16'd0, e.dep});
                check("issue_operand", {24'd0, issue_operand}, {24'd0, e.op});
                check("issue_wbs",     {24'd0, issue_wbs},     {24'd0, e.wbs});
                check("issue_flags",   {24'd0, issue_flags},   {24'd0, e.flags});
            end
            check("issue_gap", {31'd0, (cyc - last_iss) >= 2}, 32'd1);
            last_iss = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [3:0] robid, input logic [1:0] rdy,
                            input logic [3:0] t1, input logic [3:0] t0,
                            input logic [7:0] v1, input logic [7:0] v0);
        disp_robid   = robid;
        disp_operand = {4'hC, robid};
        disp_wbs     = {4'h5, robid};
        disp_flags   = {robid, 4'h9};
        disp_src_rdy = rdy;
        disp_src_tag = {t1, t0};
        disp_src_val = {v1, v0};
    endtask

    // Presents one op until accepted; queues its expected issue when push is set. Returns just after the accept edge.
    task automatic dispatch(input logic [3:0] robid, input logic [1:0] rdy,
                            input logic [3:0] t1, input logic [3:0] t0,
                            input logic [7:0] v1, input logic [7:0] v0,
                            input bit push, input logic [15:0] exp_dep);
        bit   acc;
        exp_t e;
        set_disp(robid, rdy, t1, t0, v1, v0);
        disp_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = disp_ready;
            step();
        end
        disp_valid = 1'b0;
        if (!acc) begin
            check("disp_timeout", 32'd0, 32'd1);
        end else if (push) begin
            e.robid = robid;
            e.dep   = exp_dep;
            e.op    = {4'hC, robid};
            e.wbs   = {4'h5, robid};
            e.flags = {robid, 4'h9};
            sb_q.push_back(e);
        end
    endtask

    task automatic cdb(input logic [3:0] id, input logic [7:0] val);
        cdb_valid = 1'b1;
        cdb_id    = id;
        cdb_val   = val;
        step();
        cdb_valid = 1'b0;
    endtask

    // Waits (bounded) for an issue pulse; returns at the negedge where it is seen.
    task automatic wait_issue(input string tag, input int bound);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(negedge clk);
            seen = (issue_transmit === 1'b1);
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; cdb_id = '0; cdb_val = '0;
        fu_busy = 1'b0;
        set_disp(4'd0, 2'b00, 4'd0, 4'd0, 8'd0, 8'd0);
        repeat (3) step();
        rst = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_occupancy",  {29'd0, occupancy},      32'd0);
        check("rst_disp_ready", {31'd0, disp_ready},     32'd1);
        check("rst_transmit",   {31'd0, issue_transmit}, 32'd0);
        check("rst_robid",      {28'd0, issue_robid},    32'd0);
        check("rst_depvals",    {16'd0, issue_depvals},  32'd0);
        step();

        // Both sources ready: issues at the first edge after dispatch.
        dispatch(4'd3, 2'b11, 4'd0, 4'd0, 8'd7, 8'd6, 1'b1, {8'd7, 8'd6});
        @(negedge clk);
        check("t1_occ_after_disp", {29'd0, occupancy},      32'd1);
        check("t1_no_early_issue", {31'd0, issue_transmit}, 32'd0);
        @(negedge clk);
        check("t1_issue",          {31'd0, issue_transmit}, 32'd1);
        check("t1_occ_after_iss",  {29'd0, occupancy},      32'd0);
        @(negedge clk);
        check("t1_single_pulse",   {31'd0, issue_transmit}, 32'd0);
        step();

        // src1 waits for the CDB; no CDB-to-issue bypass.
        dispatch(4'd5, 2'b01, 4'd2, 4'd0, 8'd0, 8'd1, 1'b1, {8'd9, 8'd1});
        repeat (3) begin
            @(negedge clk);
            check("t2_wait", {31'd0, issue_transmit}, 32'd0);
        end
        step();
        cdb(4'd2, 8'd9);
        @(negedge clk);
        check("t2_no_bypass", {31'd0, issue_transmit}, 32'd0);
        @(negedge clk);
        check("t2_issue",     {31'd0, issue_transmit}, 32'd1);
        step();
        step();

        // Same-cycle CDB bypass at dispatch.
        cdb_valid = 1'b1; cdb_id = 4'd4; cdb_val = 8'h11;
        dispatch(4'd7, 2'b10, 4'd0, 4'd4, 8'h33, 8'h00, 1'b1, {8'h33, 8'h11});
        cdb_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t3_bypass_issue", {31'd0, issue_transmit}, 32'd1);
        step();
        step();

        // One broadcast wakes both sources.
        dispatch(4'd6, 2'b00, 4'd5, 4'd5, 8'd0, 8'd0, 1'b1, {8'h22, 8'h22});
        step();
        cdb(4'd5, 8'h22);
        wait_issue("t3b_timeout", 10);
        step();
        step();

        // Fill with FU busy, then drain oldest-first with a 9-cycle busy window after each issue.
        fu_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dispatch(4'(8 + k), 2'b11, 4'd0, 4'd0, 8'(8'h40 + k), 8'(8'h80 + k), 1'b1,
                     {8'(8'h40 + k), 8'(8'h80 + k)});
        end
        @(negedge clk);
        check("t4_full_ready", {31'd0, disp_ready}, 32'd0);
        check("t4_full_occ",   {29'd0, occupancy},  32'd4);
        step();
        for (int k = 0; k < 4; k++) begin
            fu_busy = 1'b0;
            wait_issue("t4_timeout", 20);
            step();
            fu_busy = 1'b1;
            repeat (9) step();
        end
        fu_busy = 1'b0;
        @(negedge clk);
        check("t4_drained_occ", {29'd0, occupancy}, 32'd0);
        step();

        // Full station, one ready entry: dispatch rejected in the issue cycle, accepted next.
        fu_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dispatch(4'(1 + k), 2'b10, 4'd0, 4'd7, 8'd1, 8'd0, 1'b0, 16'd0);
        end
        dispatch(4'd4, 2'b11, 4'd0, 4'd0, 8'h55, 8'h44, 1'b1, {8'h55, 8'h44});
        @(negedge clk);
        check("t5_occ4", {29'd0, occupancy}, 32'd4);
        step();
        fu_busy = 1'b0;
        set_disp(4'd13, 2'b10, 4'd0, 4'd7, 8'd1, 8'd0);
        disp_valid = 1'b1;
        @(negedge clk);
        check("t5_ready_low_in_issue", {31'd0, disp_ready}, 32'd0);
        step();
        fu_busy = 1'b1;
        @(negedge clk);
        check("t5_occ3",      {29'd0, occupancy},      32'd3);
        check("t5_ready_hi",  {31'd0, disp_ready},     32'd1);
        check("t5_transmit",  {31'd0, issue_transmit}, 32'd1);
        step();
        disp_valid = 1'b0;
        @(negedge clk);
        check("t5_occ4_again", {29'd0, occupancy}, 32'd4);
        step();

        // Flush clears all entries; a later matching CDB must not issue anything.
        flush = 1'b1;
        step();
        flush = 1'b0;
        fu_busy = 1'b0;
        @(negedge clk);
        check("t6_flush_occ",      {29'd0, occupancy},      32'd0);
        check("t6_flush_ready",    {31'd0, disp_ready},     32'd1);
        check("t6_flush_transmit", {31'd0, issue_transmit}, 32'd0);
        step();
        cdb(4'd7, 8'h77);
        repeat (3) begin
            @(negedge clk);
            check("t6_flush_no_issue", {31'd0, issue_transmit}, 32'd0);
        end
        step();

        // Reset with three entries and an issue pending.
        fu_busy = 1'b1;
        dispatch(4'd1, 2'b10, 4'd0, 4'd1, 8'd0, 8'd0, 1'b0, 16'd0);
        dispatch(4'd2, 2'b01, 4'd2, 4'd0, 8'd0, 8'd0, 1'b0, 16'd0);
        dispatch(4'd9, 2'b11, 4'd0, 4'd0, 8'd3, 8'd4, 1'b0, 16'd0);
        @(negedge clk);
        check("t7_occ3", {29'd0, occupancy}, 32'd3);
        step();
        fu_busy = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t7_rst_occ",      {29'd0, occupancy},      32'd0);
        check("t7_rst_transmit", {31'd0, issue_transmit}, 32'd0);
        check("t7_rst_ready",    {31'd0, disp_ready},     32'd1);
        check("t7_rst_robid",    {28'd0, issue_robid},    32'd0);
        step();
        cdb(4'd1, 8'h21);
        cdb(4'd2, 8'h22);
        repeat (4) begin
            @(negedge clk);
            check("t7_rst_no_issue", {31'd0, issue_transmit}, 32'd0);
        end

        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
